// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ALU issue stage: register file, writeback bypass, two-slot output skid buffer
module alu_operand_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  input  logic [1:0]    in_aluc,
  input  logic [AW-1:0] in_rd,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_x,
  output logic [DW-1:0] out_y,
  output logic [1:0]    out_aluc,
  output logic [AW-1:0] out_rd
);

  localparam int NREG = 2 ** AW;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [1:0]    aluc;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          use_imm;
  } slot_t;

  logic [DW-1:0] rf_q [NREG];
  slot_t         out_q, out_d, skid_q, skid_d;
  logic          out_v_q, out_v_d, skid_v_q, skid_v_d;
  slot_t         new_slot, out_r, skid_r;
  logic [DW-1:0] rd_x, rd_y;
  logic          wb_hit, accept, xfer;

  // Held slots follow later writebacks so a stalled operand never goes stale.
  function automatic slot_t refresh(input slot_t s, input logic valid, input logic hit,
                                    input logic [AW-1:0] r, input logic [DW-1:0] d);
    slot_t t;
    t = s;
    if (valid && hit) begin
      if (s.rs == r) t.x = d;
      if (!s.use_imm && s.rt == r) t.y = d;
    end
    return t;
  endfunction

  assign wb_hit = wb_we && (wb_rd != '0);
  assign accept = in_valid && in_ready;
  assign xfer   = out_v_q && out_ready;

  always_comb begin
    rd_x = '0;
    rd_y = '0;
    if (in_rs != '0) rd_x = (wb_hit && wb_rd == in_rs) ? wb_data : rf_q[in_rs];
    if (in_rt != '0) rd_y = (wb_hit && wb_rd == in_rt) ? wb_data : rf_q[in_rt];
    new_slot         = '0;
    new_slot.x       = rd_x;
    new_slot.y       = in_use_imm ? in_imm : rd_y;
    new_slot.aluc    = in_aluc;
    new_slot.rd      = in_rd;
    new_slot.rs      = in_rs;
    new_slot.rt      = in_rt;
    new_slot.use_imm = in_use_imm;
  end

  always_comb begin
    out_r    = refresh(out_q, out_v_q, wb_hit, wb_rd, wb_data);
    skid_r   = refresh(skid_q, skid_v_q, wb_hit, wb_rd, wb_data);
    out_d    = out_r;
    out_v_d  = out_v_q;
    skid_d   = skid_r;
    skid_v_d = skid_v_q;
    if (xfer) begin
      if (skid_v_q) begin
        out_d    = skid_r;
        skid_v_d = 1'b0;
      end else if (accept) begin
        out_d = new_slot;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (out_v_q) begin
      if (accept) begin
        skid_d   = new_slot;
        skid_v_d = 1'b1;
      end
    end else if (accept) begin
      out_d   = new_slot;
      out_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_q    <= '0;
      skid_q   <= '0;
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      skid_q   <= skid_d;
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_hit) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign in_ready  = ~skid_v_q;
  assign out_valid = out_v_q;
  assign out_x     = out_q.x;
  assign out_y     = out_q.y;
  assign out_aluc  = out_q.aluc;
  assign out_rd    = out_q.rd;

endmodule
